nibble_add_seq: RTL and testbench

NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

---
 rtl/nibble_add_seq_pkg.sv | 37 +++
 rtl/nibble_add_seq_if.sv | 23 ++
 rtl/nibble_add_seq_cla.sv | 37 +++
 rtl/nibble_add_seq.sv | 153 +++++++++++++++
 tb/tb_nibble_add_seq.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/nibble_add_seq_pkg.sv
// Shared encodings and saturation constants for the nibble-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nibble_add_seq_pkg;

   // Operation select; the reserved code behaves exactly like ADD
   typedef enum logic [1:0] {
      OP_ADD    = 2'b00,
      OP_SUB    = 2'b01,
      OP_PADDSB = 2'b10,
      OP_RSVD   = 2'b11
   } op_e;

   // Sequencer states
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int unsigned NIBBLES = 4;

   // Saturation values for the full word and for a single packed nibble
   localparam logic [15:0] SAT_POS16 = 16'h7FFF;
   localparam logic [15:0] SAT_NEG16 = 16'h8000;
   localparam logic [3:0]  SAT_POS4  = 4'h7;
   localparam logic [3:0]  SAT_NEG4  = 4'h8;

   // Clamp a nibble toward the sign of its operands when the slice overflowed
   function automatic logic [3:0] sat_nibble(input logic [3:0] sum,
                                             input logic       ovf,
                                             input logic       sign);
      if (!ovf)
         return sum;
      return sign ? SAT_NEG4 : SAT_POS4;
   endfunction

endpackage

// File: rtl/nibble_add_seq_if.sv
// Request/response bundle between a requester and the nibble-serial adder.
// Latency: n/a (wiring only).
// Backpressure: none; requester must watch busy before raising start.
interface nibble_add_seq_if;
   logic        start;
   logic [1:0]  op;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] result;
   logic        ovfl;

   modport master (
      output start, op, a, b,
      input  busy, done, result, ovfl
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, ovfl
   );
endinterface

// File: rtl/nibble_add_seq_cla.sv
// 4-bit carry-lookahead slice with group generate/propagate and signed overflow.
// Latency: combinational.
// Backpressure: n/a.
module cla_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       g,
   output logic       p,
   output logic       ovfl
);

   logic [3:0] gi;
   logic [3:0] pi;
   logic [4:0] c;

   // Lookahead carries built directly from bit generate/propagate terms
   always_comb begin
      gi   = a & b;
      pi   = a ^ b;
      c    = 5'b0;
      c[0] = cin;
      c[1] = gi[0] | (pi[0] & cin);
      c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
      c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
           | (pi[2] & pi[1] & pi[0] & cin);
      g    = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
           | (pi[3] & pi[2] & pi[1] & gi[0]);
      p    = &pi;
      c[4] = g | (p & cin);
      s    = pi ^ c[3:0];
      // Signed overflow: carry into the sign bit differs from carry out
      ovfl = c[3] ^ c[4];
   end

endmodule

// File: rtl/nibble_add_seq.sv
// Saturating 16-bit ADD/SUB/packed-nibble add, one CLA nibble per cycle, LSB first.
// Latency: done rises 4 cycles after start is sampled; start accepted in the done cycle.
// Backpressure: start is ignored while busy=1; nothing is queued.
module nibble_add_seq
   import nibble_add_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   nibble_add_seq_if.slave  bus
);

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        carry_q, carry_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   op_e         op_q, op_d;
   logic [15:0] part_q, part_d;
   logic        pov_q, pov_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [15:0] result_q, result_d;
   logic        ovfl_q, ovfl_d;

   logic [3:0]  nib_a;
   logic [3:0]  nib_b;
   logic [3:0]  sl_b;
   logic        sl_cin;
   logic [3:0]  sl_s;
   logic        sl_g;
   logic        sl_p;
   logic        sl_ovfl;
   logic        carry_next;
   logic [3:0]  nib_store;

   // Select the current nibble pair and condition it for the requested operation
   always_comb begin
      nib_a      = a_q[{cnt_q, 2'b00} +: 4];
      nib_b      = b_q[{cnt_q, 2'b00} +: 4];
      sl_b       = (op_q == OP_SUB) ? ~nib_b : nib_b;
      // Packed mode treats every nibble as an independent lane
      sl_cin     = (op_q == OP_PADDSB) ? 1'b0 : carry_q;
      carry_next = sl_g | (sl_p & sl_cin);
      // Only packed mode clamps individual nibbles; word modes clamp at the end
      nib_store  = (op_q == OP_PADDSB) ? sat_nibble(sl_s, sl_ovfl, nib_a[3]) : sl_s;
   end

   cla_4bit u_cla_4bit (
      .a    (nib_a),
      .b    (sl_b),
      .cin  (sl_cin),
      .s    (sl_s),
      .g    (sl_g),
      .p    (sl_p),
      .ovfl (sl_ovfl)
   );

   // Next-state and registered-output logic for the IDLE/RUN sequencer
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      part_d   = part_q;
      pov_d    = pov_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      ovfl_d   = ovfl_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               op_d    = op_e'(bus.op);
               // Subtraction is a + ~b + 1, so the +1 rides in as the first carry
               carry_d = (op_e'(bus.op) == OP_SUB);
               cnt_d   = 2'd0;
               part_d  = 16'h0000;
               pov_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            part_d[{cnt_q, 2'b00} +: 4] = nib_store;
            carry_d = carry_next;
            pov_d   = pov_q | sl_ovfl;
            cnt_d   = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               if (op_q == OP_PADDSB) begin
                  result_d = {nib_store, part_q[11:0]};
                  ovfl_d   = pov_q | sl_ovfl;
               end else begin
                  // Word overflow can only occur when both operands share a's sign
                  if (sl_ovfl)
                     result_d = a_q[15] ? SAT_NEG16 : SAT_POS16;
                  else
                     result_d = {sl_s, part_q[11:0]};
                  ovfl_d = sl_ovfl;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State register; reset aborts any operation without a done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 2'd0;
         carry_q  <= 1'b0;
         a_q      <= 16'h0000;
         b_q      <= 16'h0000;
         op_q     <= OP_ADD;
         part_q   <= 16'h0000;
         pov_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= 16'h0000;
         ovfl_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         part_q   <= part_d;
         pov_q    <= pov_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         ovfl_q   <= ovfl_d;
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.ovfl   = ovfl_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Scoreboard bench for nibble_add_seq: directed operations with hand-computed results.
// Latency: each expectation carries the cycle in which done must appear.
// Backpressure: stimulus waits for busy=0 before raising start.
module tb_nibble_add_seq;

   logic clk;
   logic rst;
   int   cyc;
   int   total;
   int   bad;

   typedef struct {
      logic [15:0] res;
      logic        ov;
      int          cyc;
      string       name;
   } exp_t;

   exp_t exp_q[$];

   nibble_add_seq_if ifc();

   nibble_add_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Wait for an idle cycle, raise start for one cycle, and record the expectation
   task automatic issue(input string name, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] er, input logic eo);
      exp_t e;
      int   w;
      @(negedge clk);
      w = 0;
      while (ifc.busy && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (w >= 50) chk({name, "_idle_timeout"}, 32'd1, 32'd0);
      ifc.op    = op;
      ifc.a     = a;
      ifc.b     = b;
      ifc.start = 1'b1;
      e.res  = er;
      e.ov   = eo;
      e.cyc  = cyc + 5;
      e.name = name;
      exp_q.push_back(e);
      @(negedge clk);
      ifc.start = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) chk("drain_timeout", 32'd1, 32'd0);
      repeat (2) @(negedge clk);
   endtask

   // Monitor: every done must match the oldest expectation, including its cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (ifc.done === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk({e.name, "_result"}, {16'h0, ifc.result}, {16'h0, e.res});
               chk({e.name, "_ovfl"}, {31'h0, ifc.ovfl}, {31'h0, e.ov});
               chk({e.name, "_latency"}, cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      cyc       = 0;
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      ifc.start = 1'b0;
      ifc.op    = 2'b00;
      ifc.a     = 16'h0;
      ifc.b     = 16'h0;
      repeat (3) @(negedge clk);
      chk("reset_busy",   {31'h0, ifc.busy},   32'd0);
      chk("reset_done",   {31'h0, ifc.done},   32'd0);
      chk("reset_result", {16'h0, ifc.result}, 32'd0);
      chk("reset_ovfl",   {31'h0, ifc.ovfl},   32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic add with busy profile: high for 4 cycles, low in the done cycle
      issue("add_basic", 2'b00, 16'h1234, 16'h0FFF, 16'h2233, 1'b0);
      for (int k = 0; k < 4; k++) begin
         chk("add_basic_busy_hi", {31'h0, ifc.busy}, 32'd1);
         @(negedge clk);
      end
      chk("add_basic_busy_lo", {31'h0, ifc.busy}, 32'd0);
      drain();

      // Back-to-back sequence: each issue lands in the previous done cycle
      issue("add_sat_pos",   2'b00, 16'h7000, 16'h1000, 16'h7FFF, 1'b1);
      issue("sub_sat_neg",   2'b01, 16'h8000, 16'h0001, 16'h8000, 1'b1);
      issue("padd_mixed",    2'b10, 16'h718F, 16'h12F1, 16'h7380, 1'b1);
      issue("padd_nocarry",  2'b10, 16'h000F, 16'h0001, 16'h0000, 1'b0);
      issue("rsvd_as_add",   2'b11, 16'h0001, 16'h0002, 16'h0003, 1'b0);
      issue("add_sat_neg",   2'b00, 16'h8000, 16'h8000, 16'h8000, 1'b1);
      issue("sub_sat_pos",   2'b01, 16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b1);
      issue("padd_all_neg",  2'b10, 16'h8888, 16'h8888, 16'h8888, 1'b1);
      issue("padd_clean",    2'b10, 16'h1234, 16'h1111, 16'h2345, 1'b0);
      drain();

      // Start held high and operands scrambled while busy: single op, original result
      @(negedge clk);
      begin
         exp_t e;
         ifc.op    = 2'b01;
         ifc.a     = 16'h0005;
         ifc.b     = 16'h0007;
         ifc.start = 1'b1;
         e.res  = 16'hFFFE;
         e.ov   = 1'b0;
         e.cyc  = cyc + 5;
         e.name = "sub_held_start";
         exp_q.push_back(e);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         ifc.op = 2'b00;
         ifc.a  = 16'(32'($urandom));
         ifc.b  = 16'(32'($urandom));
      end
      @(negedge clk);
      ifc.start = 1'b0;
      drain();

      // Reset at E2 of an ADD: aborted, no done, outputs cleared
      @(negedge clk);
      ifc.op    = 2'b00;
      ifc.a     = 16'h1111;
      ifc.b     = 16'h1111;
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy",   {31'h0, ifc.busy},   32'd0);
      chk("abort_done",   {31'h0, ifc.done},   32'd0);
      chk("abort_result", {16'h0, ifc.result}, 32'd0);
      chk("abort_ovfl",   {31'h0, ifc.ovfl},   32'd0);
      rst = 1'b0;
      repeat (8) @(negedge clk);

      // Reset and start together from idle: reset wins
      rst       = 1'b1;
      ifc.start = 1'b1;
      @(negedge clk);
      chk("rst_prio_busy", {31'h0, ifc.busy}, 32'd0);
      rst       = 1'b0;
      ifc.start = 1'b0;
      repeat (6) @(negedge clk);
      chk("rst_prio_no_run", {31'h0, ifc.busy}, 32'd0);

      // Operation after reset still works
      issue("add_after_rst", 2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
      drain();
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
